// File: rtl/hilo_muldiv_seq_pkg.sv
// rtl/hilo_muldiv_seq_pkg.sv - op codes and FSM state encodings shared by the HI/LO unit and control
package hilo_muldiv_seq_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MADDU = 2'b01,
        MD_MTHI  = 2'b10,
        MD_MTLO  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } md_state_e;

    function automatic logic is_mul_op(input md_op_e o);
        return (o == MD_MULTU) || (o == MD_MADDU);
    endfunction

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one combinational shift-add step over {acc,mplr}, retiring BITS_PER_CYCLE bits
module mul_step #(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mplr,
    input  logic [DATA_W-1:0] mcand,
    output logic [DATA_W-1:0] acc_next,
    output logic [DATA_W-1:0] mplr_next
);

    localparam int B = BITS_PER_CYCLE;

    logic [DATA_W+B-1:0] partial;
    logic [DATA_W+B-1:0] sum;

    // acc + mcand*mplr[B-1:0] always fits in DATA_W+B bits, so no carry is lost
    always_comb begin
        partial = '0;
        for (int i = 0; i < B; i++) begin
            if (mplr[i]) begin
                partial = partial + ({{B{1'b0}}, mcand} << i);
            end
        end
        sum = {{B{1'b0}}, acc} + partial;
    end

    assign acc_next  = sum[DATA_W+B-1:B];
    assign mplr_next = {sum[B-1:0], mplr[DATA_W-1:B]};

endmodule

// File: rtl/hilo_muldiv_seq.sv
// rtl/hilo_muldiv_seq.sv - iterative HI/LO unit executing MULTU, MADDU, MTHI and MTLO from EX
module hilo_muldiv_seq
    import hilo_muldiv_seq_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              rd_hi_req,
    input  logic              rd_lo_req,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int N     = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    md_state_e           state;
    md_op_e              op_in;
    md_op_e              op_r;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   mplr;
    logic [DATA_W-1:0]   acc_next;
    logic [DATA_W-1:0]   mplr_next;
    logic [2*DATA_W-1:0] hilo_sum;
    logic                accept;

    assign op_in    = md_op_e'(op);
    assign accept   = start & ~flush & (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign stall    = busy & (start | rd_hi_req | rd_lo_req);
    // HI/LO are frozen while busy, so this sum uses the values held at acceptance
    assign hilo_sum = {hi, lo} + {acc, mplr};

    mul_step #(
        .DATA_W        (DATA_W),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_mul_step (
        .acc      (acc),
        .mplr     (mplr),
        .mcand    (mcand),
        .acc_next (acc_next),
        .mplr_next(mplr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            op_r  <= MD_MULTU;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
            mplr  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_in == MD_MTHI) begin
                            hi <= rs_val;
                        end else if (op_in == MD_MTLO) begin
                            lo <= rs_val;
                        end else if (is_mul_op(op_in)) begin
                            mcand <= rs_val;
                            mplr  <= rt_val;
                            acc   <= '0;
                            cnt   <= '0;
                            op_r  <= op_in;
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    acc  <= acc_next;
                    mplr <= mplr_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    // {acc,mplr} now holds the full 2*DATA_W product
                    if (op_r == MD_MADDU) begin
                        {hi, lo} <= hilo_sum;
                    end else begin
                        {hi, lo} <= {acc, mplr};
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
